// File: rtl/shooter_core.sv
// rtl/shooter_core.sv - scanned LED-matrix shooter: player, bullet lanes, respawning enemy.
// Optional saturating score counter is built only when SHOOTER_SCORE_EN is defined.
module shooter_core #(
   parameter int ROWS     = 8,
   parameter int COLS     = 16,
   parameter int SCAN_DIV = 1000,
   parameter int STEP_DIV = 2097152,
   parameter int RESPAWN  = 10,
   localparam int RW      = $clog2(ROWS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [RW-1:0]   player_row,
   input  logic            fire,
   input  logic [RW-1:0]   enemy_row,
   output logic [ROWS-1:0] row_n,
   output logic [COLS-1:0] col,
   output logic            hit,
   output logic [7:0]      score
);

   localparam int SCW = $clog2(SCAN_DIV + 1);
   localparam int STW = $clog2(STEP_DIV + 1);
   localparam int RSW = (RESPAWN < 1) ? 1 : $clog2(RESPAWN + 1);

   logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
   logic [STW-1:0] step_cnt_q, step_cnt_d;
   logic [RW-1:0]  scan_q, scan_d;
   logic [ROWS-1:0] row_n_q, row_n_d;
   logic [COLS-1:0] col_q, col_d;
   logic hit_q, hit_d;
   logic alive_q, alive_d;
   logic [RSW-1:0] resp_q, resp_d;
   logic [ROWS-1:0][COLS-1:0] lane_q, lane_d;

   logic scan_tick, step_tick, coll;
   logic [ROWS-1:0][COLS-1:0] pmask, emask, frame, post;

   assign scan_tick = (scan_cnt_q == SCW'(SCAN_DIV - 1));
   assign step_tick = (step_cnt_q == STW'(STEP_DIV - 1));

   // Masks compare in int so rows past either edge simply never match (clipping).
   always_comb begin
      pmask = '0;
      emask = '0;
      frame = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (r + 1 == int'(player_row) || r == int'(player_row) || r == int'(player_row) + 1)
            pmask[r][0] = 1'b1;
         if (r == int'(player_row))
            pmask[r][2:1] = 2'b11;
         if (r + 1 == int'(enemy_row) || r == int'(enemy_row) || r == int'(enemy_row) + 1)
            emask[r][COLS-2] = 1'b1;
         if (r == int'(enemy_row))
            emask[r][COLS-3] = 1'b1;
         frame[r] = lane_q[r] | pmask[r] | (alive_q ? emask[r] : '0);
      end
   end

   always_comb begin
      post = '0;
      coll = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         post[r] = lane_q[r] << 1;
         if (fire && r == int'(player_row))
            post[r][3] = 1'b1;
         if (alive_q && (|(post[r] & emask[r])))
            coll = 1'b1;
      end
      lane_d  = lane_q;
      alive_d = alive_q;
      resp_d  = resp_q;
      hit_d   = 1'b0;
      if (step_tick) begin
         lane_d = post;
         if (alive_q) begin
            if (coll) begin
               for (int r = 0; r < ROWS; r++)
                  lane_d[r] = post[r] & ~emask[r];
               alive_d = 1'b0;
               resp_d  = RSW'(RESPAWN);
               hit_d   = 1'b1;
            end
         end else if (resp_q > RSW'(1)) begin
            resp_d = resp_q - 1'b1;
         end else begin
            resp_d  = '0;
            alive_d = 1'b1;
         end
      end
   end

   always_comb begin
      scan_cnt_d = scan_tick ? '0 : scan_cnt_q + 1'b1;
      step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;
      scan_d     = scan_q;
      row_n_d    = row_n_q;
      col_d      = col_q;
      if (scan_tick) begin
         row_n_d = ~(ROWS'(1) << scan_q);
         for (int r = 0; r < ROWS; r++)
            if (r == int'(scan_q))
               col_d = frame[r];
         scan_d = (scan_q == '0) ? RW'(ROWS - 1) : scan_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         scan_cnt_q <= '0;
         step_cnt_q <= '0;
         scan_q     <= RW'(ROWS - 1);
         row_n_q    <= '1;
         col_q      <= '0;
         hit_q      <= 1'b0;
         alive_q    <= 1'b1;
         resp_q     <= '0;
         lane_q     <= '0;
      end else begin
         scan_cnt_q <= scan_cnt_d;
         step_cnt_q <= step_cnt_d;
         scan_q     <= scan_d;
         row_n_q    <= row_n_d;
         col_q      <= col_d;
         hit_q      <= hit_d;
         alive_q    <= alive_d;
         resp_q     <= resp_d;
         lane_q     <= lane_d;
      end
   end

   assign row_n = row_n_q;
   assign col   = col_q;
   assign hit   = hit_q;

`ifdef SHOOTER_SCORE_EN
   logic [7:0] score_q, score_d;

   // Counts on the same edge the hit pulse is registered.
   always_comb begin
      score_d = score_q;
      if (hit_d && score_q != 8'hFF)
         score_d = score_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst)
         score_q <= 8'd0;
      else
         score_q <= score_d;
   end

   assign score = score_q;
`else
   assign score = 8'd0;
`endif

endmodule
